// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: scan counter with blank gap,
// frame-synchronous double buffering, blink/blank masks, decimal points, optional hex glyphs.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_DIV    = 25000000,
    parameter int HEX_EN       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start,
    output logic                    blink_phase
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_LIM = PRESC_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d, digits_disp_q, digits_disp_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d, blink_disp_q, blink_disp_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d, blank_disp_q, blank_disp_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d, dp_disp_q, dp_disp_d;

    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_start_q, frame_start_d;

    logic                    commit;
    logic [3:0]              code;
    logic                    sel_blink, sel_blank, sel_dp, digit_off;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        s = '1;
        case (c)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: if (HEX_EN != 0) s = 7'b0001000;
            4'hB: if (HEX_EN != 0) s = 7'b1100000;
            4'hC: if (HEX_EN != 0) s = 7'b0110001;
            4'hD: if (HEX_EN != 0) s = 7'b1000010;
            4'hE: if (HEX_EN != 0) s = 7'b0110000;
            4'hF: if (HEX_EN != 0) s = 7'b0111000;
            default: s = '1;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        commit  = 1'b0;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d  = '0;
                commit = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        frame_start_d = commit;

        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        // Commit reads the shadow as it was before this edge, so a coincident load lands next frame.
        digits_sh_d   = load ? digits_in  : digits_sh_q;
        blink_sh_d    = load ? blink_mask : blink_sh_q;
        blank_sh_d    = load ? blank_mask : blank_sh_q;
        dp_sh_d       = load ? dp_in      : dp_sh_q;
        digits_disp_d = commit ? digits_sh_q : digits_disp_q;
        blink_disp_d  = commit ? blink_sh_q  : blink_disp_q;
        blank_disp_d  = commit ? blank_sh_q  : blank_disp_q;
        dp_disp_d     = commit ? dp_sh_q     : dp_disp_q;

        code      = '0;
        sel_blink = 1'b0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        an_n_d    = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code      = digits_disp_q[4*i +: 4];
                sel_blink = blink_disp_q[i];
                sel_blank = blank_disp_q[i];
                sel_dp    = dp_disp_q[i];
                if (presc_q >= BLANK_LIM) an_n_d[i] = 1'b0;
            end
        end

        digit_off = sel_blank | (sel_blink & blink_phase_q);
        seg_n_d   = digit_off ? 7'h7F : decode(code);
        dp_n_d    = digit_off ? 1'b1  : ~sel_dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digits_sh_q   <= '0;
            blink_sh_q    <= '0;
            blank_sh_q    <= '0;
            dp_sh_q       <= '0;
            digits_disp_q <= '0;
            blink_disp_q  <= '0;
            blank_disp_q  <= '0;
            dp_disp_q     <= '0;
            seg_n_q       <= '1;
            dp_n_q        <= 1'b1;
            an_n_q        <= '1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            digits_sh_q   <= digits_sh_d;
            blink_sh_q    <= blink_sh_d;
            blank_sh_q    <= blank_sh_d;
            dp_sh_q       <= dp_sh_d;
            digits_disp_q <= digits_disp_d;
            blink_disp_q  <= blink_disp_d;
            blank_disp_q  <= blank_disp_d;
            dp_disp_q     <= dp_disp_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign an_n        = an_n_q;
    assign frame_start = frame_start_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: hex and non-hex instances share stimulus and are
// compared every cycle against a time-indexed model of the scan, blink and frame rules.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int BD    = 8;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  seg_h, seg_d;
    logic        dp_h, dp_d;
    logic [3:0]  an_h, an_d;
    logic        fs_h, fs_d;
    logic        bp_h, bp_d;

    int errors = 0;
    int checks = 0;

    // Model: t = cycles since reset release (state seen before the next edge).
    int          t = 0;
    logic [15:0] sh_dig = '0, ds_dig = '0;
    logic [3:0]  sh_blink = '0, ds_blink = '0;
    logic [3:0]  sh_blank = '0, ds_blank = '0;
    logic [3:0]  sh_dp = '0, ds_dp = '0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_DIV(BD), .HEX_EN(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .blink_mask(blink_mask), .blank_mask(blank_mask), .dp_in(dp_in),
        .seg_n(seg_h), .dp_n(dp_h), .an_n(an_h), .frame_start(fs_h), .blink_phase(bp_h)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_DIV(BD), .HEX_EN(0)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .blink_mask(blink_mask), .blank_mask(blank_mask), .dp_in(dp_in),
        .seg_n(seg_d), .dp_n(dp_d), .an_n(an_d), .frame_start(fs_d), .blink_phase(bp_d)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an_hex"},  32'(an_h),  32'hF);
        chk({tag, "_an_dec"},  32'(an_d),  32'hF);
        chk({tag, "_seg_hex"}, 32'(seg_h), 32'h7F);
        chk({tag, "_seg_dec"}, 32'(seg_d), 32'h7F);
        chk({tag, "_dp"},      32'(dp_h),  32'h1);
        chk({tag, "_fs"},      32'(fs_h),  32'h0);
        chk({tag, "_bp"},      32'(bp_h),  32'h0);
    endtask

    task automatic model_reset();
        t = 0;
        sh_dig = '0; ds_dig = '0; sh_blink = '0; ds_blink = '0;
        sh_blank = '0; ds_blank = '0; sh_dp = '0; ds_dp = '0;
    endtask

    // One clock edge: predict the registered outputs from the pre-edge state, advance the model, compare.
    task automatic tick();
        int         p, ix, ph, ph_next;
        logic [3:0] a, code;
        logic       off, dpx, fs;
        logic [6:0] sh, sd;
        @(posedge clk);
        p       = t % SD;
        ix      = (t / SD) % ND;
        ph      = (t / BD) % 2;
        ph_next = ((t + 1) / BD) % 2;
        a       = (p < BC) ? 4'hF : ~(4'b0001 << ix);
        code    = ds_dig[ix*4 +: 4];
        off     = ds_blank[ix] || (ds_blink[ix] && ph == 1);
        sh      = off ? 7'h7F : glyph[code];
        sd      = off ? 7'h7F : ((code > 4'd9) ? 7'h7F : glyph[code]);
        dpx     = off ? 1'b1 : ~ds_dp[ix];
        fs      = (t % FRAME) == FRAME - 1;
        if (fs) begin
            ds_dig = sh_dig; ds_blink = sh_blink; ds_blank = sh_blank; ds_dp = sh_dp;
        end
        if (load) begin
            sh_dig = digits_in; sh_blink = blink_mask; sh_blank = blank_mask; sh_dp = dp_in;
        end
        t++;
        #1;
        chk("an_hex",  32'(an_h),  32'(a));
        chk("an_dec",  32'(an_d),  32'(a));
        chk("seg_hex", 32'(seg_h), 32'(sh));
        chk("seg_dec", 32'(seg_d), 32'(sd));
        chk("dp_hex",  32'(dp_h),  32'(dpx));
        chk("dp_dec",  32'(dp_d),  32'(dpx));
        chk("frame_start", 32'(fs_h), 32'(fs));
        chk("blink_phase", 32'(bp_h), 32'(ph_next));
    endtask

    task automatic load_once(input logic [15:0] dg, input logic [3:0] bl, input logic [3:0] bk,
                             input logic [3:0] dp);
        digits_in = dg; blink_mask = bl; blank_mask = bk; dp_in = dp; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_frame_pos(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick();
    endtask

    initial begin
        // Reset hold
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_off("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First frames show zeros with the gap/digit scan sequence
        run(2 * FRAME);

        // Mid-frame load stays hidden until the frame commit
        run_until_frame_pos(5);
        load_once(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Load on the commit edge lands one frame later
        run_until_frame_pos(FRAME - 1);
        load_once(16'h5678, 4'b0000, 4'b0000, 4'b1010);
        run(2 * FRAME + 3);

        // Blink on digit 1, permanent blank on digit 0
        load_once(16'h8888, 4'b0010, 4'b0001, 4'b1111);
        run(4 * FRAME);

        // Hex glyphs vs blanked codes, dp on digit 2 only
        load_once(16'hFACE, 4'b0000, 4'b0000, 4'b0100);
        run(2 * FRAME + 2);

        // Randomized loads
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) begin
                digits_in  = 16'($urandom);
                blink_mask = 4'($urandom);
                blank_mask = 4'($urandom & $urandom);
                dp_in      = 4'($urandom);
                load       = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;

        // Asynchronous reset during digit 2's slot
        for (int i = 0; i < FRAME && ((t - 1) % FRAME) != 10; i++) tick();
        chk("pre_reset_an", 32'(an_h), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk_off("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_off("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
